op_link_rst_ctrl: RTL

OP_LINK_RST_CTRL -- requirements
Module: op_link_rst_ctrl

---
 rtl/op_link_rst_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/op_link_rst_ctrl.sv
// Optical link reset controller: per-channel transmitter-disable pulse sequencer
// with settle holdoff, completion strobe and saturating reset-event counters.
module op_link_rst_ctrl #(
    parameter int NCHAN     = 2,
    parameter int CNT_W     = 12,
    parameter int PULSE_DUR = 4000,
    parameter int HOLDOFF   = 16
) (
    input  logic                 CLK,
    input  logic                 RST_B,
    input  logic                 STRTUP_OP_RST,
    input  logic [NCHAN-1:0]     OP_RST,
    input  logic [NCHAN-1:0]     CHAN_EN,
    input  logic                 CLR_CNT,
    output logic [NCHAN-1:0]     TDIS,
    output logic                 ANY_TDIS,
    output logic [NCHAN-1:0]     BUSY,
    output logic [NCHAN-1:0]     DONE,
    output logic [8*NCHAN-1:0]   EVT_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TX_DIS  = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_DUR - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF - 1);
    localparam bit               HAS_HOLDOFF  = (HOLDOFF > 0);

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        state_t           state_r;
        logic [CNT_W-1:0] cnt_r;
        logic [7:0]       evt_r;
        logic             tdis_r;
        logic             done_r;
        logic             req_s;
        logic             start_s;

        assign req_s   = CHAN_EN[i] & (STRTUP_OP_RST | OP_RST[i]);
        assign start_s = (state_r == ST_IDLE) && req_s;

        // Channel sequencer: pulse, optional settle, then park until the request drops.
        always_ff @(posedge CLK or negedge RST_B) begin
            if (!RST_B) begin
                state_r <= ST_IDLE;
                cnt_r   <= {CNT_W{1'b0}};
                tdis_r  <= 1'b0;
                done_r  <= 1'b0;
            end else begin
                done_r <= 1'b0;
                case (state_r)
                    ST_IDLE: begin
                        if (req_s) begin
                            state_r <= ST_TX_DIS;
                            cnt_r   <= {CNT_W{1'b0}};
                            tdis_r  <= 1'b1;
                        end
                    end
                    ST_TX_DIS: begin
                        if (cnt_r == PULSE_LAST) begin
                            cnt_r  <= {CNT_W{1'b0}};
                            tdis_r <= 1'b0;
                            if (HAS_HOLDOFF) begin
                                state_r <= ST_HOLDOFF;
                            end else begin
                                done_r  <= 1'b1;
                                state_r <= req_s ? ST_WAIT : ST_IDLE;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    ST_HOLDOFF: begin
                        if (cnt_r == HOLDOFF_LAST) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            done_r  <= 1'b1;
                            state_r <= req_s ? ST_WAIT : ST_IDLE;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    ST_WAIT: begin
                        if (!req_s) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                        tdis_r  <= 1'b0;
                    end
                endcase
            end
        end

        // Event counter: a clear coinciding with a new start leaves exactly one event.
        always_ff @(posedge CLK or negedge RST_B) begin
            if (!RST_B) begin
                evt_r <= 8'd0;
            end else if (CLR_CNT) begin
                evt_r <= start_s ? 8'd1 : 8'd0;
            end else if (start_s && (evt_r != 8'hFF)) begin
                evt_r <= evt_r + 8'd1;
            end else begin
                evt_r <= evt_r;
            end
        end

        assign TDIS[i]         = tdis_r;
        assign DONE[i]         = done_r;
        assign BUSY[i]         = (state_r != ST_IDLE);
        assign EVT_CNT[8*i +: 8] = evt_r;
    end

    assign ANY_TDIS = |TDIS;

endmodule
